// File: rtl/ha.sv
// Registered WIDTH-lane half adder; optional counters with HA_STATS_EN.
// Latency 1 cycle; C/S hold while in_valid=0.
// No backpressure: every in_valid sample is accepted.
module ha #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] S
`ifdef HA_STATS_EN
  ,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  logic [WIDTH-1:0] carry_nxt;
  logic [WIDTH-1:0] sum_nxt;

  assign carry_nxt = A & B;
  assign sum_nxt   = A ^ B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      C         <= '0;
      S         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        C <= carry_nxt;
        S <= sum_nxt;
      end
    end
  end

`ifdef HA_STATS_EN
  // Counters saturate at all-ones so long runs never alias back to small values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      carry_cnt  <= '0;
    end else if (in_valid) begin
      if (sample_cnt != '1)
        sample_cnt <= sample_cnt + 1'b1;
      if ((|carry_nxt) && (carry_cnt != '1))
        carry_cnt <= carry_cnt + 1'b1;
    end
  end
`endif

  a_cs_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(|(C & S)));

endmodule

// File: tb/tb_ha.sv
// Directed-vector bench for ha: 1-lane and 4-lane instances driven in parallel.
module tb_ha;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;

  logic       ov1;
  logic [0:0] c1;
  logic [0:0] s1;
  logic       ov4;
  logic [3:0] c4;
  logic [3:0] s4;

`ifdef HA_STATS_EN
  logic [15:0] sc1, cc1, sc4, cc4;
  logic [1:0]  scs, ccs;
  logic        ovs;
  logic [0:0]  cs, ss;
`endif

  int passed;
  int total;

  ha #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a[0:0]), .B(b[0:0]),
    .out_valid(ov1), .C(c1), .S(s1)
`ifdef HA_STATS_EN
    , .sample_cnt(sc1), .carry_cnt(cc1)
`endif
  );

  ha #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
    .out_valid(ov4), .C(c4), .S(s4)
`ifdef HA_STATS_EN
    , .sample_cnt(sc4), .carry_cnt(cc4)
`endif
  );

`ifdef HA_STATS_EN
  ha #(.WIDTH(1), .CNT_W(2)) us (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a[0:0]), .B(b[0:0]),
    .out_valid(ovs), .C(cs), .S(ss), .sample_cnt(scs), .carry_cnt(ccs)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic       ov;
    logic [3:0] c;
    logic [3:0] s;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [3:0] c, input logic [3:0] s);
    chk({tag, " ov4"}, 16'(ov4), 16'(ov));
    chk({tag, " c4"},  16'(c4),  16'(c));
    chk({tag, " s4"},  16'(s4),  16'(s));
    chk({tag, " ov1"}, 16'(ov1), 16'(ov));
    chk({tag, " c1"},  16'(c1),  16'(c[0]));
    chk({tag, " s1"},  16'(s1),  16'(s[0]));
  endtask

  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    in_valid = v;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total = 0;
    // Lane 0 walks the truth table 00,01,10,11; upper lanes exercise independence.
    tbl[0]  = '{1'b1, 4'b1100, 4'b1010, 1'b1, 4'b1000, 4'b0110};
    tbl[1]  = '{1'b1, 4'b0110, 4'b0011, 1'b1, 4'b0010, 4'b0101};
    tbl[2]  = '{1'b1, 4'b1011, 4'b0110, 1'b1, 4'b0010, 4'b1101};
    tbl[3]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b0000};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    tbl[9]  = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b1111};
    tbl[10] = '{1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0101, 4'b0000};
    tbl[11] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0101, 4'b0000};
    tbl[12] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111};

    rst_n = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    #2 rst_n = 1'b0;
    #1 chk_all("reset", 1'b0, 4'b0000, 4'b0000);
`ifdef HA_STATS_EN
    chk("reset sample_cnt", sc4, 16'd0);
    chk("reset carry_cnt", cc4, 16'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].b);
      chk_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].c, tbl[i].s);
    end

    // Mid-cycle async reset while C=1.
    drive(1'b1, 4'b1111, 4'b1111);
    chk_all("pre_arst", 1'b1, 4'b1111, 4'b0000);
    #2 rst_n = 1'b0;
    #1 chk_all("mid_arst", 1'b0, 4'b0000, 4'b0000);

    // Sample presented during reset is discarded; no out_valid pulse after release.
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'b1111;
    b = 4'b1111;
    @(posedge clk);
    #1 chk_all("in_rst", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all("post_rel", 1'b0, 4'b0000, 4'b0000);

    // First valid after release captures normally.
    drive(1'b1, 4'b0001, 4'b1000);
    chk_all("first_cap", 1'b1, 4'b0000, 4'b1001);

`ifdef HA_STATS_EN
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b0000, 4'b0000);
    drive(1'b1, 4'b0000, 4'b0001);
    drive(1'b1, 4'b0001, 4'b0000);
    drive(1'b1, 4'b0001, 4'b0001);
    chk("stats1 sample", sc1, 16'd4);
    chk("stats1 carry",  cc1, 16'd1);
    chk("stats4 sample", sc4, 16'd4);
    chk("stats4 carry",  cc4, 16'd1);
    chk("sat sample 4", 16'(scs), 16'd3);
    chk("sat carry 4",  16'(ccs), 16'd1);
    for (int k = 0; k < 5; k++) drive(1'b1, 4'b0001, 4'b0001);
    drive(1'b0, 4'b0001, 4'b0001);
    chk("stats4 sample 9", sc4, 16'd9);
    chk("stats4 carry 6",  cc4, 16'd6);
    chk("sat sample", 16'(scs), 16'd3);
    chk("sat carry",  16'(ccs), 16'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ha.md
HA -- requirements
Module: ha

Interface
REQ-001 Parameter WIDTH, default 1: number of independent half-adder lanes.
REQ-002 Parameter CNT_W, default 16: counter width, used only when HA_STATS_EN is defined.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: A and B carry a sample this cycle.
REQ-006 Port A, input, WIDTH bits: addend A, one bit per lane.
REQ-007 Port B, input, WIDTH bits: addend B, one bit per lane.
REQ-008 Port out_valid, output, 1 bit: C and S hold the result of a newly captured sample.
REQ-009 Port C, output, WIDTH bits: per-lane carry, registered.
REQ-010 Port S, output, WIDTH bits: per-lane sum, registered.
REQ-011 Port sample_cnt, output, CNT_W bits: accepted-sample count; present only with HA_STATS_EN.
REQ-012 Port carry_cnt, output, CNT_W bits: count of accepted samples with any C bit set; present only with HA_STATS_EN.

Function
REQ-013 Each lane i SHALL compute S[i] = A[i] XOR B[i] and C[i] = A[i] AND B[i].
- Truth table: 00->C0 S0, 01->C0 S1, 10->C0 S1, 11->C1 S0.
REQ-014 On a rising clk edge with in_valid=1, the module SHALL register C and S from the current A and B.
- Latency: exactly 1 cycle.
REQ-015 On a rising clk edge with in_valid=0, C and S SHALL hold their previous values.
REQ-016 out_valid SHALL equal in_valid delayed by one cycle.
- Back-to-back valid samples: one result per cycle, no bubbles.
REQ-017 A and B SHALL have no effect on C, S or out_valid unless in_valid=1.
REQ-018 C and S SHALL never both be 1 in the same lane.
- A verification assertion SHALL check this.
REQ-019 Each lane SHALL be independent.
- No carry propagates between lanes.

Reset
REQ-020 While rst_n=0, C, S and out_valid SHALL be 0 asynchronously, without waiting for a clk edge.
- With HA_STATS_EN, sample_cnt and carry_cnt SHALL also be 0.
REQ-021 After rst_n deasserts, the first rising edge with in_valid=1 SHALL capture normally.
REQ-022 If reset asserts while a sample is in flight, that sample SHALL be discarded and out_valid SHALL not pulse for it.

Configuration
REQ-023 Macro HA_STATS_EN SHALL enable the sample_cnt and carry_cnt ports and logic.
REQ-024 With HA_STATS_EN defined, counter updates SHALL follow these rules.
- sample_cnt increments on each accepted sample.
- carry_cnt increments on each accepted sample whose computed C is nonzero.
- Both counters saturate at all-ones and do not wrap.
- Both counters update in the same cycle as C and S.
REQ-025 Without HA_STATS_EN, the counter ports and logic SHALL be absent.
- All other behaviour SHALL be unchanged.

Verification
REQ-026 Exhaustive truth table: WIDTH=1, in_valid=1, apply A,B = 00, 01, 10, 11 on successive cycles -> (C,S) one cycle later = 00, 01, 01, 10.
REQ-027 Hold: capture A=1, B=1, then in_valid=0 with A=0, B=0 for 5 cycles -> C=1, S=0 held and out_valid=0.
REQ-028 Async reset: drive rst_n low mid-cycle while C=1 -> C, S and out_valid go to 0 before the next clk edge.
REQ-029 Multi-lane: WIDTH=4, A=4'b1100, B=4'b1010 -> C=4'b1000, S=4'b0110.
REQ-030 Statistics (HA_STATS_EN): apply 4 valid samples 00, 01, 10, 11 -> sample_cnt=4, carry_cnt=1.
- With CNT_W=2 and 5 samples of 11 -> both counters saturate at 3.
